// File: rtl/cport_host.sv
// Cport host initiator: moves one 16-bit word as four nibbles (LSN first) over the Cport link.
// Optional handshake timeout with automatic link reset: define CPORT_HOST_TIMEOUT_EN.
module cport_host #(
  parameter int SETUP_CYCLES   = 2,
  parameter int RESET_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Dir,
  input  logic [15:0] WrData,
  input  logic        ResetReq,
  output logic [15:0] RdData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [3:0]  CPDataOut,
  input  logic [3:0]  CPDataIn,
  output logic        CPDataOe,
  input  logic        CPReady,
  output logic        CPReset,
  output logic        CPDir,
  output logic        CPStrobe
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LRST     = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_SETUP    = 3'd3,
    S_STROBE   = 3'd4,
    S_RELEASE  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] RESET_LAST = 8'(RESET_CYCLES - 1);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || RESET_CYCLES < 1 || RESET_CYCLES > 255 ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("cport_host: parameter out of range");
  end

  state_t      state_q, state_d;
  logic        rdy_meta_q, rdy_q;
  logic [3:0]  din_meta_q, din_q;
  logic        dir_q, dir_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [3:0]  cp_data_out_q, cp_data_out_d;
  logic        cp_data_oe_q, cp_data_oe_d;
  logic        cp_reset_q, cp_reset_d;
  logic        cp_dir_q, cp_dir_d;
  logic        cp_strobe_q, cp_strobe_d;
  logic        timeout_s;
  logic        xfer_s;

`ifdef CPORT_HOST_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;
  logic        wait_state_s;
`endif

  // Two-flop synchronizer for the device-driven ready and data pins.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rdy_meta_q <= 1'b0;
      rdy_q      <= 1'b0;
      din_meta_q <= 4'd0;
      din_q      <= 4'd0;
    end else begin
      rdy_meta_q <= CPReady;
      rdy_q      <= rdy_meta_q;
      din_meta_q <= CPDataIn;
      din_q      <= din_meta_q;
    end
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      dir_q         <= 1'b0;
      wdata_q       <= 16'd0;
      idx_q         <= 2'd0;
      cnt_q         <= 8'd0;
      shadow_q      <= 16'd0;
      rd_data_q     <= 16'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      cp_data_out_q <= 4'd0;
      cp_data_oe_q  <= 1'b0;
      cp_reset_q    <= 1'b0;
      cp_dir_q      <= 1'b0;
      cp_strobe_q   <= 1'b0;
`ifdef CPORT_HOST_TIMEOUT_EN
      tmo_q         <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      wdata_q       <= wdata_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      rd_data_q     <= rd_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      cp_data_out_q <= cp_data_out_d;
      cp_data_oe_q  <= cp_data_oe_d;
      cp_reset_q    <= cp_reset_d;
      cp_dir_q      <= cp_dir_d;
      cp_strobe_q   <= cp_strobe_d;
`ifdef CPORT_HOST_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  // Next-state logic; SETUP also waits for rdy so the strobe never rises against a busy device.
  always_comb begin
    state_d   = state_q;
    timeout_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ResetReq) begin
          state_d = S_LRST;
        end else if (Start) begin
          state_d = S_WAIT_RDY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LRST: begin
        if (cnt_q == RESET_LAST) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LRST;
        end
      end
      S_WAIT_RDY: begin
        if (rdy_q) begin
          state_d = S_SETUP;
        end else begin
          state_d = S_WAIT_RDY;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST && rdy_q) begin
          state_d = S_STROBE;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_STROBE: begin
        if (!rdy_q) begin
          state_d = S_RELEASE;
        end else begin
          state_d = S_STROBE;
        end
      end
      S_RELEASE: begin
        if (!rdy_q) begin
          state_d = S_RELEASE;
        end else if (idx_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef CPORT_HOST_TIMEOUT_EN
    wait_state_s = (state_q == S_WAIT_RDY) || (state_q == S_STROBE) || (state_q == S_RELEASE);
    if (wait_state_s && state_d == state_q && tmo_q == TMO_LAST) begin
      state_d   = S_LRST;
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
`endif
  end

  // Datapath: request capture, cycle counters, nibble index and read shadow.
  always_comb begin
    dir_d    = dir_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (state_q == S_IDLE && state_d == S_WAIT_RDY) begin
      dir_d   = Dir;
      wdata_d = WrData;
      idx_d   = 2'd0;
    end else if (state_q == S_RELEASE && state_d == S_SETUP) begin
      idx_d = idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
    // cnt saturates in SETUP so a late rdy does not wrap the setup count.
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (state_q == S_LRST || (state_q == S_SETUP && cnt_q != SETUP_LAST)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
    if (state_q == S_STROBE && !rdy_q && !dir_q) begin
      shadow_d[{idx_q, 2'b00} +: 4] = din_q;
    end else begin
      shadow_d = shadow_q;
    end
`ifdef CPORT_HOST_TIMEOUT_EN
    if (state_d != state_q) begin
      tmo_d = 16'd0;
    end else if (wait_state_s) begin
      tmo_d = tmo_q + 16'd1;
    end else begin
      tmo_d = tmo_q;
    end
`endif
  end

  // Output decode from the next state so every pin comes straight from a flop.
  always_comb begin
    xfer_s      = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_RELEASE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    error_d     = timeout_s;
    cp_reset_d  = (state_d == S_LRST);
    cp_strobe_d = (state_d == S_STROBE);
    if (xfer_s) begin
      cp_dir_d     = dir_q;
      cp_data_oe_d = dir_q;
    end else begin
      cp_dir_d     = 1'b0;
      cp_data_oe_d = 1'b0;
    end
    if (xfer_s && dir_q) begin
      cp_data_out_d = wdata_q[{idx_d, 2'b00} +: 4];
    end else begin
      cp_data_out_d = 4'd0;
    end
    if (state_d == S_DONE && state_q != S_DONE && !dir_q) begin
      rd_data_d = shadow_d;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  assign RdData    = rd_data_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Error     = error_q;
  assign CPDataOut = cp_data_out_q;
  assign CPDataOe  = cp_data_oe_q;
  assign CPReset   = cp_reset_q;
  assign CPDir     = cp_dir_q;
  assign CPStrobe  = cp_strobe_q;

endmodule

// File: tb/tb_cport_host.sv
// Bench for cport_host: table of word transfers checked through a scoreboard, plus link-reset,
// held-ready, mid-transfer reset and (with CPORT_HOST_TIMEOUT_EN) timeout sequences.
`timescale 1ns/1ps
module tb_cport_host;
  localparam int SETUP_CYCLES = 2;
  localparam int RESET_CYCLES = 16;
`ifdef CPORT_HOST_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = 64;
`else
  localparam int TIMEOUT_CYCLES = 1024;
`endif

  logic        Clk, Reset, Start, Dir, ResetReq, CPReady;
  logic [15:0] WrData, RdData;
  logic        Busy, Done, Error, CPDataOe, CPReset, CPDir, CPStrobe;
  logic [3:0]  CPDataOut, CPDataIn;

  cport_host #(.SETUP_CYCLES(SETUP_CYCLES), .RESET_CYCLES(RESET_CYCLES),
               .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Dir(Dir), .WrData(WrData),
    .ResetReq(ResetReq), .RdData(RdData), .Busy(Busy), .Done(Done), .Error(Error),
    .CPDataOut(CPDataOut), .CPDataIn(CPDataIn), .CPDataOe(CPDataOe), .CPReady(CPReady),
    .CPReset(CPReset), .CPDir(CPDir), .CPStrobe(CPStrobe)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic        dir;
    logic [15:0] wdata;
    logic [15:0] dev_word;
    int          ack_delay;
    logic [15:0] exp_rd;
  } vec_t;

  typedef struct {
    logic        dir;
    logic [15:0] wdata;
    logic [15:0] rd;
  } sb_t;

  vec_t        vecs[6];
  sb_t         sb_q[$];
  int          checks, errors;
  logic [15:0] model_rd;
  int          stable_base, done_base, strobe_base, error_base;

  // device model controls (written by the main sequence only)
  logic        dev_hold_low, dev_never_ack;
  logic [15:0] dev_word;
  int          ack_delay;

  // device model state (written by the device process only)
  logic [3:0]  out_log[$];
  logic        dir_log[$];
  logic        oe_log[$];
  int          stable_viol, done_seen, error_seen, strobe_total, ack_cnt, nib_k;
  logic        strobe_prev, acking;
  logic [3:0]  last_out;
  logic        last_dir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, 32'({RdData, Busy, Done, Error, CPDataOut, CPDataOe, CPReset, CPDir, CPStrobe}), 32'd0);
  endtask

  // Device: strobe -> present nibble, drop ready after ack_delay; ready returns once strobe is low.
  initial begin
    CPReady = 1'b1; CPDataIn = 4'd0; strobe_prev = 1'b0; acking = 1'b0; ack_cnt = 0; nib_k = 0;
    stable_viol = 0; done_seen = 0; error_seen = 0; strobe_total = 0; last_out = 4'd0; last_dir = 1'b0;
    forever begin
      @(posedge Clk);
      #2;
      if (Done)  done_seen++;
      if (Error) error_seen++;
      if (Reset || Start) begin
        nib_k = 0;
        out_log.delete(); dir_log.delete(); oe_log.delete();
        acking = 1'b0;
      end
      if (CPStrobe && !strobe_prev) begin
        strobe_total++;
        out_log.push_back(CPDataOut);
        dir_log.push_back(CPDir);
        oe_log.push_back(CPDataOe);
        last_out = CPDataOut;
        last_dir = CPDir;
        CPDataIn = dev_word[4*(nib_k%4) +: 4];
        nib_k++;
        ack_cnt = ack_delay;
        acking = !dev_never_ack;
      end else if (CPStrobe && strobe_prev) begin
        if (CPDataOut !== last_out || CPDir !== last_dir) stable_viol++;
      end
      if (dev_hold_low) begin
        CPReady = 1'b0;
      end else if (acking) begin
        if (ack_cnt == 0) begin
          CPReady = 1'b0;
          acking = 1'b0;
        end else begin
          ack_cnt--;
        end
      end else if (!CPStrobe) begin
        CPReady = 1'b1;
      end
      strobe_prev = CPStrobe;
    end
  end

  task automatic start_xfer(input logic dir, input logic [15:0] wdata, input logic [15:0] exp_rd);
    sb_t e;
    e.dir = dir; e.wdata = wdata; e.rd = exp_rd;
    stable_base = stable_viol;
    done_base   = done_seen;
    Dir = dir; WrData = wdata; Start = 1'b1;
    sb_q.push_back(e);
    @(negedge Clk);
    Start = 1'b0;
    chk("busy_after_start", 32'(Busy), 32'd1);
  endtask

  task automatic wait_done(input string name);
    sb_t e;
    int  n;
    n = 0;
    while (!Done && n < 600) begin
      @(negedge Clk);
      n++;
    end
    if (!Done) begin
      chk({name, "_done_timeout"}, 32'(Done), 32'd1);
      sb_q.delete();
      return;
    end
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({name, "_rddata"}, 32'(RdData), 32'(e.rd));
    chk({name, "_strobes"}, 32'(out_log.size()), 32'd4);
    if (out_log.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk({name, "_nibble"}, 32'(out_log[k]), e.dir ? 32'(e.wdata[4*k +: 4]) : 32'd0);
        chk({name, "_cpdir"}, 32'(dir_log[k]), 32'(e.dir));
        chk({name, "_cpdataoe"}, 32'(oe_log[k]), 32'(e.dir));
      end
    end
    chk({name, "_stable_under_strobe"}, 32'(stable_viol - stable_base), 32'd0);
    @(negedge Clk);
    chk({name, "_done_once"}, 32'(done_seen - done_base), 32'd1);
    chk({name, "_idle_after"}, 32'({Done, Busy, CPDataOe}), 32'd0);
  endtask

  initial begin : main
    int n;
    int hi;
    logic flag;
    Reset = 1'b1; Start = 1'b0; Dir = 1'b0; WrData = 16'd0; ResetReq = 1'b0;
    dev_hold_low = 1'b0; dev_never_ack = 1'b0; dev_word = 16'd0; ack_delay = 1;
    checks = 0; errors = 0; model_rd = 16'd0;

    vecs[0] = '{1'b1, 16'hA5C3, 16'h0000, 3, 16'h0000};
    vecs[1] = '{1'b0, 16'h0000, 16'h91E7, 1, 16'h91E7};
    vecs[2] = '{1'b1, 16'h1234, 16'hFFFF, 0, 16'h91E7};
    vecs[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 2, 16'hFFFF};
    vecs[4] = '{1'b0, 16'h0000, 16'h0C30, 5, 16'h0C30};
    vecs[5] = '{1'b1, 16'hFFFF, 16'h0000, 1, 16'h0C30};

    repeat (3) @(negedge Clk);
    chk_outputs_zero("reset_state");
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    chk_outputs_zero("idle_after_reset");
    error_base = error_seen;

    for (int i = 0; i < 6; i++) begin
      dev_word  = vecs[i].dev_word;
      ack_delay = vecs[i].ack_delay;
      start_xfer(vecs[i].dir, vecs[i].wdata, vecs[i].exp_rd);
      wait_done($sformatf("vec%0d", i));
      model_rd = vecs[i].exp_rd;
    end

    // CPReady held low: no strobe while waiting, then completes once released.
    dev_hold_low = 1'b1;
    ack_delay = 1;
    repeat (4) @(negedge Clk);
    start_xfer(1'b1, 16'h5A5A, model_rd);
    flag = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (CPStrobe || !Busy) flag = 1'b1;
    end
    chk("held_ready_no_strobe", 32'(flag), 32'd0);
    dev_hold_low = 1'b0;
    wait_done("held_ready");

    // ResetReq and Start together: link reset wins; Start during LRST ignored.
    strobe_base = strobe_total;
    done_base   = done_seen;
    ResetReq = 1'b1; Start = 1'b1; Dir = 1'b1; WrData = 16'hFFFF;
    @(negedge Clk);
    ResetReq = 1'b0; Start = 1'b0;
    chk("lrst_busy", 32'({Busy, CPReset, CPStrobe, CPDataOe}), 32'b1100);
    hi = 1;
    n = 0;
    while (CPReset && n < 100) begin
      Start = (n == 4);
      @(negedge Clk);
      if (CPReset) hi++;
      n++;
    end
    Start = 1'b0;
    chk("lrst_cycles", 32'(hi), 32'(RESET_CYCLES));
    repeat (4) @(negedge Clk);
    chk("lrst_busy_low_after", 32'(Busy), 32'd0);
    chk("lrst_no_transfer", 32'(strobe_total - strobe_base), 32'd0);
    chk("lrst_no_done", 32'(done_seen - done_base), 32'd0);

    // Reset asserted during the strobe of nibble 2 aborts the transfer.
    ack_delay = 4;
    start_xfer(1'b1, 16'hBEEF, model_rd);
    n = 0;
    while (!(out_log.size() == 3 && CPStrobe) && n < 400) begin
      @(negedge Clk);
      n++;
    end
    chk("abort_reached_nibble2", 32'(out_log.size() == 3 && CPStrobe), 32'd1);
    Reset = 1'b1;
    #1;
    chk_outputs_zero("abort_async_outputs");
    @(negedge Clk);
    chk_outputs_zero("abort_held_outputs");
    Reset = 1'b0;
    sb_q.delete();
    model_rd = 16'd0;
    repeat (3) @(negedge Clk);
    chk("abort_no_done", 32'(done_seen - done_base), 32'd0);
    ack_delay = 2;
    start_xfer(1'b1, 16'h0001, model_rd);
    wait_done("after_abort");

`ifdef CPORT_HOST_TIMEOUT_EN
    // Device never acknowledges: Error after TIMEOUT_CYCLES in STROBE, then link reset.
    dev_never_ack = 1'b1;
    start_xfer(1'b1, 16'h1234, model_rd);
    n = 0;
    while (!CPStrobe && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("tmo_strobe_seen", 32'(CPStrobe), 32'd1);
    n = 0;
    while (!Error && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("tmo_error_delay", 32'(n), 32'(TIMEOUT_CYCLES));
    chk("tmo_lrst_entry", 32'({CPReset, CPStrobe}), 32'b10);
    n = 0;
    while (CPReset && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("tmo_no_done", 32'(done_seen - done_base), 32'd0);
    chk("tmo_rddata_kept", 32'(RdData), 32'(model_rd));
    chk("tmo_error_once", 32'(error_seen - error_base), 32'd1);
    sb_q.delete();
    dev_never_ack = 1'b0;
`else
    chk("no_error_pulses", 32'(error_seen - error_base), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
